// File: rtl/risk_pkg.sv
// Shared types and constants for the risk tile command sequencer.
// Covers the address widths, risk unit function codes, sequencer states and command opcodes.
package risk_pkg;

    localparam int RISK_LOGCNT = 5;
    localparam int RISK_AW     = 10 + RISK_LOGCNT;
    localparam int RISK_SW     = RISK_AW - 1;

    typedef enum logic [2:0] {
        LOAD  = 3'b000,
        STORE = 3'b001,
        ZERO  = 3'b010,
        NOP   = 3'b111
    } risk_func_e;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ISSUE,
        HOLD,
        NEXT,
        DONE
    } seq_state_e;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_STORE = 2'd1,
        OP_ZERO  = 2'd2,
        OP_RSVD  = 2'd3
    } cmd_op_e;

    // The reserved opcode still walks the grid but never touches the risk unit.
    function automatic risk_func_e op_to_func(input cmd_op_e op);
        case (op)
            OP_LOAD:  return LOAD;
            OP_STORE: return STORE;
            OP_ZERO:  return ZERO;
            default:  return NOP;
        endcase
    endfunction

endpackage

// File: rtl/risk_seq_if.sv
// Command bus from the scalar core plus the control outputs toward the risk unit.
// The master modport is the command issuer; the slave modport is the sequencer.
interface risk_seq_if
    import risk_pkg::*;
#(
    parameter int AW     = RISK_AW,
    parameter int SW     = RISK_SW,
    parameter int NREG_W = 5
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [NREG_W-1:0] cmd_reg;
    logic [AW-1:0]     cmd_base;
    logic [SW-1:0]     cmd_stride_x;
    logic [SW-1:0]     cmd_stride_y;
    logic [AW-1:0]     cmd_pitch_x;
    logic [AW-1:0]     cmd_pitch_y;
    logic [3:0]        cmd_nx;
    logic [3:0]        cmd_ny;

    logic [2:0]        risk_func;
    logic [NREG_W-1:0] risk_reg;
    logic [AW-1:0]     risk_addr;
    logic [SW-1:0]     risk_stride_x;
    logic [SW-1:0]     risk_stride_y;
    logic              busy;
    logic              done;

    modport master (
        output cmd_valid, cmd_op, cmd_reg, cmd_base, cmd_stride_x, cmd_stride_y,
               cmd_pitch_x, cmd_pitch_y, cmd_nx, cmd_ny,
        input  cmd_ready, risk_func, risk_reg, risk_addr, risk_stride_x, risk_stride_y,
               busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_reg, cmd_base, cmd_stride_x, cmd_stride_y,
               cmd_pitch_x, cmd_pitch_y, cmd_nx, cmd_ny,
        output cmd_ready, risk_func, risk_reg, risk_addr, risk_stride_x, risk_stride_y,
               busy, done
    );

endinterface

// File: rtl/risk_seq_agen.sv
// Tile-grid walker: keeps tile/row addresses, tile counters and register index.
// It loads on command accept and steps once per advance strobe.
module risk_seq_agen
    import risk_pkg::*;
#(
    parameter int AW     = RISK_AW,
    parameter int NREG_W = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_load,
    input  logic              i_advance,
    input  logic [AW-1:0]     i_base,
    input  logic [AW-1:0]     i_pitch_x,
    input  logic [AW-1:0]     i_pitch_y,
    input  logic [3:0]        i_nx,
    input  logic [3:0]        i_ny,
    input  logic [NREG_W-1:0] i_reg,
    output logic [AW-1:0]     o_tile_addr,
    output logic [NREG_W-1:0] o_reg_idx,
    output logic              o_last
);

    logic [AW-1:0]     r_pitch_x;
    logic [AW-1:0]     r_pitch_y;
    logic [3:0]        r_nx;
    logic [3:0]        r_ny;
    logic [3:0]        r_tx;
    logic [3:0]        r_ty;
    logic [AW-1:0]     r_row_base;
    logic [AW-1:0]     r_tile_addr;
    logic [NREG_W-1:0] r_reg_idx;

    logic [AW-1:0]     w_row_next;
    logic              w_last;

    assign w_row_next = r_row_base + r_pitch_y;
    assign w_last     = (r_tx == r_nx) && (r_ty == r_ny);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pitch_x   <= '0;
            r_pitch_y   <= '0;
            r_nx        <= '0;
            r_ny        <= '0;
            r_tx        <= '0;
            r_ty        <= '0;
            r_row_base  <= '0;
            r_tile_addr <= '0;
            r_reg_idx   <= '0;
        end else if (i_load) begin
            r_pitch_x   <= i_pitch_x;
            r_pitch_y   <= i_pitch_y;
            r_nx        <= i_nx;
            r_ny        <= i_ny;
            r_tx        <= '0;
            r_ty        <= '0;
            r_row_base  <= i_base;
            r_tile_addr <= i_base;
            r_reg_idx   <= i_reg;
        end else if (i_advance && !w_last) begin
            r_reg_idx <= r_reg_idx + NREG_W'(1);
            // tx never exceeds nx, so "not equal" is the same as "less than".
            if (r_tx != r_nx) begin
                r_tx        <= r_tx + 4'(1);
                r_tile_addr <= r_tile_addr + r_pitch_x;
            end else begin
                r_tx        <= '0;
                r_ty        <= r_ty + 4'(1);
                r_row_base  <= w_row_next;
                r_tile_addr <= w_row_next;
            end
        end
    end

    assign o_tile_addr = r_tile_addr;
    assign o_reg_idx   = r_reg_idx;
    assign o_last      = w_last;

endmodule

// File: rtl/risk_seq.sv
// Risk unit command sequencer: accepts a 2D tile-grid transfer and issues one
// load/store/zero per tile, holding the address stable LAT cycles either side.
module risk_seq
    import risk_pkg::*;
#(
    parameter int LOGCNT = RISK_LOGCNT,
    parameter int LAT    = 4,
    parameter int NREG_W = 5
) (
    input  logic     clk,
    input  logic     resetn,
    risk_seq_if.slave bus
);

    localparam int AW = 10 + LOGCNT;
    localparam int SW = AW - 1;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

    seq_state_e        r_state;
    logic [CW-1:0]     r_cnt;
    cmd_op_e           r_op;
    risk_func_e        r_func;
    logic [NREG_W-1:0] r_reg;
    logic [SW-1:0]     r_stride_x;
    logic [SW-1:0]     r_stride_y;
    logic              r_busy;
    logic              r_done;
    logic              r_ready;

    logic              w_accept;
    logic              w_advance;
    logic [AW-1:0]     w_tile_addr;
    logic [NREG_W-1:0] w_reg_idx;
    logic              w_last;

    assign w_accept  = (r_state == IDLE) && r_ready && bus.cmd_valid;
    assign w_advance = (r_state == NEXT);

    risk_seq_agen #(
        .AW     (AW),
        .NREG_W (NREG_W)
    ) u_agen (
        .clk         (clk),
        .resetn      (resetn),
        .i_load      (w_accept),
        .i_advance   (w_advance),
        .i_base      (bus.cmd_base),
        .i_pitch_x   (bus.cmd_pitch_x),
        .i_pitch_y   (bus.cmd_pitch_y),
        .i_nx        (bus.cmd_nx),
        .i_ny        (bus.cmd_ny),
        .i_reg       (bus.cmd_reg),
        .o_tile_addr (w_tile_addr),
        .o_reg_idx   (w_reg_idx),
        .o_last      (w_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_op       <= OP_LOAD;
            r_func     <= NOP;
            r_reg      <= '0;
            r_stride_x <= '0;
            r_stride_y <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op       <= cmd_op_e'(bus.cmd_op);
                        r_stride_x <= bus.cmd_stride_x;
                        r_stride_y <= bus.cmd_stride_y;
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_cnt      <= CNT_INIT;
                        r_state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (r_cnt == '0) begin
                        r_func  <= op_to_func(r_op);
                        r_reg   <= w_reg_idx;
                        r_state <= ISSUE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ISSUE: begin
                    r_func  <= NOP;
                    r_cnt   <= CNT_INIT;
                    r_state <= HOLD;
                end
                HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= NEXT;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                NEXT: begin
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt   <= CNT_INIT;
                        r_state <= SETUP;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The address comes straight from the walker's tile register, which only moves after NEXT.
    assign bus.risk_addr     = w_tile_addr;
    assign bus.risk_func     = r_func;
    assign bus.risk_reg      = r_reg;
    assign bus.risk_stride_x = r_stride_x;
    assign bus.risk_stride_y = r_stride_y;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.cmd_ready     = r_ready;

endmodule

// File: tb/tb_risk_seq.sv
// Directed bench for risk_seq: a table of transfers with hand-computed results,
// plus hand-written sequences for reset, issue order and back-to-back commands.
module tb_risk_seq;

    localparam int LAT = 4;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  rg;
        logic [14:0] base;
        logic [13:0] sx;
        logic [13:0] sy;
        logic [14:0] px;
        logic [14:0] py;
        logic [3:0]  nx;
        logic [3:0]  ny;
        int          n_iss;
        logic [14:0] first_addr;
        logic [14:0] last_addr;
        logic [4:0]  last_reg;
        logic [2:0]  func;
        int          done_cyc;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    int   n_assert;
    int   n_fail;

    logic [14:0] iss_addr[$];
    logic [4:0]  iss_reg[$];
    logic [2:0]  iss_func[$];
    int          iss_cyc[$];

    risk_seq_if bus();

    risk_seq dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [4:0] rg,
                                input logic [14:0] base, input logic [13:0] sx,
                                input logic [13:0] sy, input logic [14:0] px,
                                input logic [14:0] py, input logic [3:0] nx,
                                input logic [3:0] ny, input int n,
                                input logic [14:0] fa, input logic [14:0] la,
                                input logic [4:0] lr, input logic [2:0] f, input int dc);
        vec_t v;
        v.op = op; v.rg = rg; v.base = base; v.sx = sx; v.sy = sy;
        v.px = px; v.py = py; v.nx = nx; v.ny = ny; v.n_iss = n;
        v.first_addr = fa; v.last_addr = la; v.last_reg = lr; v.func = f; v.done_cyc = dc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.cmd_op       = v.op;
        bus.cmd_reg      = v.rg;
        bus.cmd_base     = v.base;
        bus.cmd_stride_x = v.sx;
        bus.cmd_stride_y = v.sy;
        bus.cmd_pitch_x  = v.px;
        bus.cmd_pitch_y  = v.py;
        bus.cmd_nx       = v.nx;
        bus.cmd_ny       = v.ny;
    endtask

    task automatic scramble();
        bus.cmd_op       = 2'($urandom);
        bus.cmd_reg      = 5'($urandom);
        bus.cmd_base     = 15'($urandom);
        bus.cmd_stride_x = 14'($urandom);
        bus.cmd_stride_y = 14'($urandom);
        bus.cmd_pitch_x  = 15'($urandom);
        bus.cmd_pitch_y  = 15'($urandom);
        bus.cmd_nx       = 4'($urandom);
        bus.cmd_ny       = 4'($urandom);
    endtask

    // Starts and ends on a falling edge. With chain set, nv is presented with
    // valid held high right after v is accepted.
    task automatic run_xfer(input string tag, input vec_t v, input bit chain, input vec_t nv);
        int          k;
        int          run;
        int          hold_left;
        bit          prev_nn;
        bit          got_done;
        logic [14:0] held;
        logic [14:0] prev_addr;
        drive(v);
        bus.cmd_valid = 1'b1;
        chk({tag, " ready_before_accept"}, 32'(bus.cmd_ready), 1);
        iss_addr.delete(); iss_reg.delete(); iss_func.delete(); iss_cyc.delete();
        @(posedge clk);
        @(negedge clk);
        if (chain) begin
            drive(nv);
            bus.cmd_valid = 1'b1;
        end else begin
            scramble();
            bus.cmd_valid = 1'b0;
        end
        k = 1; run = 1; hold_left = 0; prev_nn = 1'b0; got_done = 1'b0;
        held = '0; prev_addr = bus.risk_addr;
        while (!got_done && k < 3000) begin
            if (k > 1) run = (bus.risk_addr == prev_addr) ? run + 1 : 1;
            prev_addr = bus.risk_addr;
            chk($sformatf("%s busy@%0d", tag, k), 32'(bus.busy), 1);
            chk($sformatf("%s ready_low@%0d", tag, k), 32'(bus.cmd_ready), 0);
            if (hold_left > 0) begin
                chk($sformatf("%s hold_addr@%0d", tag, k), 32'(bus.risk_addr), 32'(held));
                hold_left--;
            end
            if (bus.risk_func != 3'b111) begin
                chk($sformatf("%s back_to_back@%0d", tag, k), 32'(prev_nn), 0);
                chk($sformatf("%s setup_stable@%0d", tag, k), 32'(run >= LAT + 1), 1);
                iss_addr.push_back(bus.risk_addr);
                iss_reg.push_back(bus.risk_reg);
                iss_func.push_back(bus.risk_func);
                iss_cyc.push_back(k);
                held = bus.risk_addr;
                hold_left = LAT;
                prev_nn = 1'b1;
            end else begin
                prev_nn = 1'b0;
            end
            if (bus.done) begin
                got_done = 1'b1;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        chk({tag, " done_latency"}, got_done ? 32'(k) : 32'hFFFF_FFFF, 32'(v.done_cyc));
        chk({tag, " issue_count"}, 32'(iss_addr.size()), 32'(v.n_iss));
        chk({tag, " stride_x"}, 32'(bus.risk_stride_x), 32'(v.sx));
        chk({tag, " stride_y"}, 32'(bus.risk_stride_y), 32'(v.sy));
        if (iss_addr.size() > 0) begin
            chk({tag, " first_addr"}, 32'(iss_addr[0]), 32'(v.first_addr));
            chk({tag, " last_addr"}, 32'(iss_addr[iss_addr.size()-1]), 32'(v.last_addr));
            chk({tag, " last_reg"}, 32'(iss_reg[iss_reg.size()-1]), 32'(v.last_reg));
        end
        for (int i = 0; i < iss_addr.size(); i++) begin
            chk($sformatf("%s reg[%0d]", tag, i), 32'(iss_reg[i]), 32'(5'(v.rg + i)));
            chk($sformatf("%s func[%0d]", tag, i), 32'(iss_func[i]), 32'(v.func));
            chk($sformatf("%s cycle[%0d]", tag, i), 32'(iss_cyc[i]), 32'(LAT + 1 + i * (2 * LAT + 2)));
        end
        @(negedge clk);
        chk({tag, " done_pulse_end"}, 32'(bus.done), 0);
        chk({tag, " busy_end"}, 32'(bus.busy), 0);
        chk({tag, " ready_end"}, 32'(bus.cmd_ready), 1);
        chk({tag, " func_end"}, 32'(bus.risk_func), 32'h7);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " func"}, 32'(bus.risk_func), 32'h7);
        chk({tag, " reg"}, 32'(bus.risk_reg), 0);
        chk({tag, " addr"}, 32'(bus.risk_addr), 0);
        chk({tag, " stride_x"}, 32'(bus.risk_stride_x), 0);
        chk({tag, " stride_y"}, 32'(bus.risk_stride_y), 0);
        chk({tag, " busy"}, 32'(bus.busy), 0);
        chk({tag, " done"}, 32'(bus.done), 0);
        chk({tag, " ready"}, 32'(bus.cmd_ready), 1);
    endtask

    vec_t        tbl[7];
    vec_t        v3, va, vb, vr;
    logic [14:0] exp3_addr[4];
    logic [4:0]  exp3_reg[4];
    int          n_done;
    int          n_nonnop;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        //            op    rg     base      sx       sy       px       py       nx ny  n  first    last     lreg  func    done
        tbl[0] = mk(2'd0, 5'd3,  15'h0100, 14'h0011, 14'h0022, 15'h0011, 15'h0022, 0, 0, 1, 15'h0100, 15'h0100, 5'd3,  3'b000, 11);
        tbl[1] = mk(2'd2, 5'd7,  15'h7FF0, 14'h0001, 14'h0002, 15'h0020, 15'h0000, 1, 0, 2, 15'h7FF0, 15'h0010, 5'd8,  3'b010, 21);
        tbl[2] = mk(2'd3, 5'd4,  15'h0200, 14'h0123, 14'h0456, 15'h0008, 15'h0000, 1, 0, 0, 15'h0000, 15'h0000, 5'd0,  3'b111, 21);
        tbl[3] = mk(2'd0, 5'd0,  15'h1000, 14'h3FFF, 14'h2AAA, 15'h0100, 15'h2000, 2, 1, 6, 15'h1000, 15'h3200, 5'd5,  3'b000, 61);
        tbl[4] = mk(2'd1, 5'd31, 15'h0ABC, 14'h0040, 14'h0080, 15'h0000, 15'h0000, 1, 1, 4, 15'h0ABC, 15'h0ABC, 5'd2,  3'b001, 41);
        tbl[5] = mk(2'd0, 5'd10, 15'h4000, 14'h1234, 14'h0F0F, 15'h0000, 15'h6000, 0, 2, 3, 15'h4000, 15'h0000, 5'd12, 3'b000, 31);
        tbl[6] = mk(2'd1, 5'd0,  15'h0000, 14'h0005, 14'h0006, 15'h0001, 15'h0000, 15, 0, 16, 15'h0000, 15'h000F, 5'd15, 3'b001, 161);

        resetn = 1'b0;
        bus.cmd_valid = 1'b0;
        drive(tbl[0]);
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_xfer($sformatf("tbl%0d", i), tbl[i], 1'b0, tbl[i]);
        end

        // 2x2 store: exact issue order with register wrap 30,31,0,1.
        v3 = mk(2'd1, 5'd30, 15'h0010, 14'h0003, 14'h0004, 15'h0004, 15'h0040, 1, 1, 4, 15'h0010, 15'h0054, 5'd1, 3'b001, 41);
        exp3_addr = '{15'h0010, 15'h0014, 15'h0050, 15'h0054};
        exp3_reg  = '{5'd30, 5'd31, 5'd0, 5'd1};
        run_xfer("grid2x2", v3, 1'b0, v3);
        for (int i = 0; i < 4; i++) begin
            if (i < iss_addr.size()) begin
                chk($sformatf("grid2x2 seq_addr[%0d]", i), 32'(iss_addr[i]), 32'(exp3_addr[i]));
                chk($sformatf("grid2x2 seq_reg[%0d]", i), 32'(iss_reg[i]), 32'(exp3_reg[i]));
            end
        end

        // Back-to-back: valid stays high, second command waits for ready.
        va = mk(2'd0, 5'd3, 15'h0100, 14'h0AAA, 14'h0BBB, 15'h0000, 15'h0000, 0, 0, 1, 15'h0100, 15'h0100, 5'd3, 3'b000, 11);
        vb = mk(2'd1, 5'd9, 15'h0200, 14'h1111, 14'h2222, 15'h0000, 15'h0000, 0, 0, 1, 15'h0200, 15'h0200, 5'd9, 3'b001, 11);
        run_xfer("b2b_first", va, 1'b1, vb);
        run_xfer("b2b_second", vb, 1'b0, vb);

        // Reset in the middle of SETUP of a 4-tile load.
        vr = mk(2'd0, 5'd20, 15'h1234, 14'h0055, 14'h0066, 15'h0001, 15'h0002, 1, 1, 4, 15'h1234, 15'h1237, 5'd23, 3'b000, 41);
        drive(vr);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("midsetup addr", 32'(bus.risk_addr), 32'h1234);
        chk("midsetup stride_x", 32'(bus.risk_stride_x), 32'h55);
        resetn = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        resetn = 1'b1;
        n_done = 0;
        n_nonnop = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) n_done++;
            if (bus.risk_func != 3'b111) n_nonnop++;
        end
        chk("after_rst no_done", 32'(n_done), 0);
        chk("after_rst no_issue", 32'(n_nonnop), 0);
        chk("after_rst ready", 32'(bus.cmd_ready), 1);
        run_xfer("after_rst", tbl[0], 1'b0, tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
